// File: rtl/instr_sequencer_fsm.sv
// -----------------------------------------------------------------------------
// instr_sequencer_fsm
//   Control FSM between the instruction decoder and the datapath. Accepts an
//   instruction from the CPU wrapper (s while idle), latches the decoder fields,
//   and steps the datapath through read-A, read-B, execute and write-back,
//   emitting the register-file / ALU load strobes.
//
//   Configuration macro: CTRL_ILLEGAL_TRAP_EN
//     defined     : an unsupported instruction parks the FSM in ILLEGAL
//                   (illegal=1, w=0) until rst_n is asserted.
//     not defined : ILLEGAL is a one-cycle illegal pulse, then back to WAIT;
//                   the instruction is a NOP and is not counted.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   s                 start request (sampled only in WAIT)
//   opcode, op        decoder fields (latched on acceptance)
//   w                 idle in WAIT, ready for s
//   nsel              one-hot register select [2]=Rn [1]=Rd [0]=Rm
//   vsel              write-back source 00=C 10=sximm8
//   loada/loadb/loadc A/B/C register loads
//   asel              force ALU A input to 0
//   loads             status flag load
//   write             register-file write enable
//   illegal           unsupported instruction accepted
//   instr_count       retired instructions (wraps silently)
//
// Sequences (edge 0 accepts s):
//   MOV imm : WAIT -> DECODE -> WR_IMM -> WAIT
//   MOV reg/MVN : WAIT -> DECODE -> GET_B -> EXEC -> WR_REG -> WAIT
//   CMP     : WAIT -> DECODE -> GET_A -> GET_B -> EXEC -> WAIT
//   ADD/AND : WAIT -> DECODE -> GET_A -> GET_B -> EXEC -> WR_REG -> WAIT
//
// Outputs are flops loaded from a decode of the next state, so they behave as
// pure Moore outputs of the current state without combinational paths from
// the inputs.
// -----------------------------------------------------------------------------
module instr_sequencer_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s,
    input  logic [2:0]       opcode,
    input  logic [1:0]       op,
    output logic             w,
    output logic [2:0]       nsel,
    output logic [1:0]       vsel,
    output logic             loada,
    output logic             loadb,
    output logic             asel,
    output logic             loadc,
    output logic             loads,
    output logic             write,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    // Four-bit encoding leaves spare codes; those fall into the default arm.
    typedef enum logic [3:0] {
        ST_WAIT    = 4'd0,
        ST_DECODE  = 4'd1,
        ST_GET_A   = 4'd2,
        ST_GET_B   = 4'd3,
        ST_EXEC    = 4'd4,
        ST_WR_REG  = 4'd5,
        ST_WR_IMM  = 4'd6,
        ST_ILLEGAL = 4'd7
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_q, w_d;
    logic [2:0]       nsel_q, nsel_d;
    logic [1:0]       vsel_q, vsel_d;
    logic             loada_q, loada_d;
    logic             loadb_q, loadb_d;
    logic             asel_q, asel_d;
    logic             loadc_q, loadc_d;
    logic             loads_q, loads_d;
    logic             write_q, write_d;
    logic             illegal_q, illegal_d;

    logic             is_cmp_q_s;
    logic             is_cmp_d_s;
    logic             is_asel_d_s;

    // Instruction classes from the latched fields (current and next copies).
    always_comb begin
        is_cmp_q_s  = (opcode_q == 3'b101) && (op_q == 2'b01);
        is_cmp_d_s  = (opcode_d == 3'b101) && (op_d == 2'b01);
        is_asel_d_s = ((opcode_d == 3'b110) && (op_d == 2'b00)) ||
                      ((opcode_d == 3'b101) && (op_d == 2'b11));
    end

    // Next-state, field latch and retire counter.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (s) begin
                    opcode_d = opcode;
                    op_d     = op;
                    state_d  = ST_DECODE;
                end else begin
                    state_d  = ST_WAIT;
                end
            end
            ST_DECODE: begin
                case ({opcode_q, op_q})
                    5'b110_10: state_d = ST_WR_IMM;
                    5'b110_00: state_d = ST_GET_B;
                    5'b101_00,
                    5'b101_01,
                    5'b101_10: state_d = ST_GET_A;
                    5'b101_11: state_d = ST_GET_B;
                    default:   state_d = ST_ILLEGAL;
                endcase
            end
            ST_GET_A: state_d = ST_GET_B;
            ST_GET_B: state_d = ST_EXEC;
            ST_EXEC: begin
                if (is_cmp_q_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_WR_REG;
                end
            end
            ST_WR_REG, ST_WR_IMM: begin
                state_d = ST_WAIT;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_ILLEGAL: state_d = ST_ILLEGAL;
`else
            ST_ILLEGAL: state_d = ST_WAIT;
`endif
            default: state_d = ST_WAIT;
        endcase
    end

    // Output decode of the state being entered; flopped below.
    always_comb begin
        w_d       = 1'b0;
        nsel_d    = 3'b000;
        vsel_d    = 2'b00;
        loada_d   = 1'b0;
        loadb_d   = 1'b0;
        asel_d    = 1'b0;
        loadc_d   = 1'b0;
        loads_d   = 1'b0;
        write_d   = 1'b0;
        illegal_d = 1'b0;
        case (state_d)
            ST_WAIT:   w_d = 1'b1;
            ST_DECODE: w_d = 1'b0;
            ST_GET_A: begin
                nsel_d  = 3'b100;
                loada_d = 1'b1;
            end
            ST_GET_B: begin
                nsel_d  = 3'b001;
                loadb_d = 1'b1;
            end
            ST_EXEC: begin
                if (is_cmp_d_s) begin
                    loads_d = 1'b1;
                end else begin
                    loadc_d = 1'b1;
                    asel_d  = is_asel_d_s;
                end
            end
            ST_WR_REG: begin
                nsel_d  = 3'b010;
                vsel_d  = 2'b00;
                write_d = 1'b1;
            end
            ST_WR_IMM: begin
                nsel_d  = 3'b100;
                vsel_d  = 2'b10;
                write_d = 1'b1;
            end
            ST_ILLEGAL: illegal_d = 1'b1;
            default:    w_d = 1'b0;
        endcase
    end

    // State, latched fields, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_WAIT;
            opcode_q  <= 3'b000;
            op_q      <= 2'b00;
            cnt_q     <= {CNT_W{1'b0}};
            w_q       <= 1'b1;
            nsel_q    <= 3'b000;
            vsel_q    <= 2'b00;
            loada_q   <= 1'b0;
            loadb_q   <= 1'b0;
            asel_q    <= 1'b0;
            loadc_q   <= 1'b0;
            loads_q   <= 1'b0;
            write_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            w_q       <= w_d;
            nsel_q    <= nsel_d;
            vsel_q    <= vsel_d;
            loada_q   <= loada_d;
            loadb_q   <= loadb_d;
            asel_q    <= asel_d;
            loadc_q   <= loadc_d;
            loads_q   <= loads_d;
            write_q   <= write_d;
            illegal_q <= illegal_d;
        end
    end

    assign w           = w_q;
    assign nsel        = nsel_q;
    assign vsel        = vsel_q;
    assign loada       = loada_q;
    assign loadb       = loadb_q;
    assign asel        = asel_q;
    assign loadc       = loadc_q;
    assign loads       = loads_q;
    assign write       = write_q;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer_fsm.sv
// Table-driven bench for instr_sequencer_fsm (built with CNT_W=2 so counter
// wrap is reachable). Output bundle order:
// {w, nsel[2:0], vsel[1:0], loada, loadb, asel, loadc, loads, write, illegal}
module tb_instr_sequencer_fsm;
    localparam int CNT_W = 2;

    localparam logic [12:0] O_WAIT  = 13'h1000;
    localparam logic [12:0] O_DEC   = 13'h0000;
    localparam logic [12:0] O_GETA  = 13'h0840;
    localparam logic [12:0] O_GETB  = 13'h0220;
    localparam logic [12:0] O_EXALU = 13'h0008;
    localparam logic [12:0] O_EXCMP = 13'h0004;
    localparam logic [12:0] O_EXMOV = 13'h0018;
    localparam logic [12:0] O_WRREG = 13'h0402;
    localparam logic [12:0] O_WRIMM = 13'h0902;
    localparam logic [12:0] O_ILL   = 13'h0001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s;
    logic [2:0]       opcode;
    logic [1:0]       op;
    logic             w, loada, loadb, asel, loadc, loads, write, illegal;
    logic [2:0]       nsel;
    logic [1:0]       vsel;
    logic [CNT_W-1:0] instr_count;
    logic [12:0]      obs;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             s;
        logic [2:0]       opcode;
        logic [1:0]       op;
        logic [12:0]      exp_o;
        logic [CNT_W-1:0] exp_c;
    } vec_t;

    vec_t vecs[$];

    instr_sequencer_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
        .asel(asel), .loadc(loadc), .loads(loads), .write(write),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign obs = {w, nsel, vsel, loada, loadb, asel, loadc, loads, write, illegal};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [12:0] eo, input logic [CNT_W-1:0] ec);
        total++;
        if (obs !== eo || instr_count !== ec) begin
            bad++;
            $display("FAIL %s: got out=%h cnt=%0d, want out=%h cnt=%0d", nm, obs, instr_count, eo, ec);
        end
    endtask

    task automatic drive(input logic si, input logic [2:0] oc, input logic [1:0] o);
        s = si; opcode = oc; op = o;
    endtask

    task automatic add(input logic si, input logic [2:0] oc, input logic [1:0] o,
                       input logic [12:0] eo, input logic [CNT_W-1:0] ec);
        vec_t v;
        v.s = si; v.opcode = oc; v.op = o; v.exp_o = eo; v.exp_c = ec;
        vecs.push_back(v);
    endtask

    initial begin
        // back-to-back MOV imm with s held: counts 1,2,3,0,1
        for (int k = 0; k < 5; k++) begin
            add(1'b1, 3'b110, 2'b10, O_DEC,   CNT_W'(k));
            add(1'b1, 3'b110, 2'b10, O_WRIMM, CNT_W'(k));
            add(1'b1, 3'b110, 2'b10, O_WAIT,  CNT_W'(k + 1));
        end
        add(1'b0, 3'b110, 2'b10, O_WAIT, 2'd1);
        // ADD; opcode changed to MOV imm after acceptance
        add(1'b1, 3'b101, 2'b00, O_DEC,   2'd1);
        add(1'b0, 3'b110, 2'b10, O_GETA,  2'd1);
        add(1'b0, 3'b110, 2'b10, O_GETB,  2'd1);
        add(1'b0, 3'b110, 2'b10, O_EXALU, 2'd1);
        add(1'b0, 3'b110, 2'b10, O_WRREG, 2'd1);
        add(1'b0, 3'b110, 2'b10, O_WAIT,  2'd2);
        // CMP
        add(1'b1, 3'b101, 2'b01, O_DEC,   2'd2);
        add(1'b0, 3'b111, 2'b11, O_GETA,  2'd2);
        add(1'b0, 3'b111, 2'b11, O_GETB,  2'd2);
        add(1'b0, 3'b111, 2'b11, O_EXCMP, 2'd2);
        add(1'b0, 3'b111, 2'b11, O_WAIT,  2'd3);
        // MOV reg
        add(1'b1, 3'b110, 2'b00, O_DEC,   2'd3);
        add(1'b0, 3'b111, 2'b11, O_GETB,  2'd3);
        add(1'b0, 3'b111, 2'b11, O_EXMOV, 2'd3);
        add(1'b0, 3'b111, 2'b11, O_WRREG, 2'd3);
        add(1'b0, 3'b111, 2'b11, O_WAIT,  2'd0);
        // MVN
        add(1'b1, 3'b101, 2'b11, O_DEC,   2'd0);
        add(1'b0, 3'b000, 2'b00, O_GETB,  2'd0);
        add(1'b0, 3'b000, 2'b00, O_EXMOV, 2'd0);
        add(1'b0, 3'b000, 2'b00, O_WRREG, 2'd0);
        add(1'b0, 3'b000, 2'b00, O_WAIT,  2'd1);
        // AND
        add(1'b1, 3'b101, 2'b10, O_DEC,   2'd1);
        add(1'b0, 3'b000, 2'b00, O_GETA,  2'd1);
        add(1'b0, 3'b000, 2'b00, O_GETB,  2'd1);
        add(1'b0, 3'b000, 2'b00, O_EXALU, 2'd1);
        add(1'b0, 3'b000, 2'b00, O_WRREG, 2'd1);
        add(1'b0, 3'b000, 2'b00, O_WAIT,  2'd2);
        // MOV imm, single-cycle s
        add(1'b1, 3'b110, 2'b10, O_DEC,   2'd2);
        add(1'b0, 3'b000, 2'b00, O_WRIMM, 2'd2);
        add(1'b0, 3'b000, 2'b00, O_WAIT,  2'd3);

        rst_n = 1'b0;
        drive(1'b0, 3'b000, 2'b00);
        tick();
        check("reset", O_WAIT, 2'd0);
        rst_n = 1'b1;
        tick();
        check("idle", O_WAIT, 2'd0);

        // one MOV imm so the counter is non-zero before the abort
        drive(1'b1, 3'b110, 2'b10); tick(); check("pre_dec", O_DEC, 2'd0);
        drive(1'b0, 3'b000, 2'b00); tick(); check("pre_wrimm", O_WRIMM, 2'd0);
        tick(); check("pre_wait", O_WAIT, 2'd1);

        // reset while ADD sits in GET_B
        drive(1'b1, 3'b101, 2'b00); tick(); check("abort_dec", O_DEC, 2'd1);
        drive(1'b0, 3'b101, 2'b00); tick(); check("abort_geta", O_GETA, 2'd1);
        tick(); check("abort_getb", O_GETB, 2'd1);
        rst_n = 1'b0;
        tick(); check("abort_rst", O_WAIT, 2'd0);
        rst_n = 1'b1;
        tick(); check("abort_after", O_WAIT, 2'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].s, vecs[i].opcode, vecs[i].op);
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].exp_c);
        end

`ifdef CTRL_ILLEGAL_TRAP_EN
        drive(1'b1, 3'b111, 2'b00); tick(); check("trap_dec", O_DEC, 2'd3);
        tick(); check("trap_ill", O_ILL, 2'd3);
        for (int k = 0; k < 3; k++) begin
            tick(); check("trap_hold", O_ILL, 2'd3);
        end
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 2'b00);
        tick(); check("trap_rst", O_WAIT, 2'd0);
        rst_n = 1'b1;
        tick(); check("trap_after", O_WAIT, 2'd0);
`else
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       drive(1'b1, 3'b111, 2'b00);
                1:       drive(1'b1, 3'b110, 2'b01);
                default: drive(1'b1, 3'b100, 2'b11);
            endcase
            tick(); check("ill_dec", O_DEC, 2'd3);
            drive(1'b0, 3'b000, 2'b00);
            tick(); check("ill_pulse", O_ILL, 2'd3);
            tick(); check("ill_wait", O_WAIT, 2'd3);
            tick(); check("ill_idle", O_WAIT, 2'd3);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
